reaction_timer: RTL and testbench

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer.sv | 161 ++++++++++++++++
 tb/tb_reaction_timer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// Reaction timer: after a pseudo-random delay the lamp lights, and the time to the button press
// is measured in ms. Early presses are fouls and slow responses saturate at MAX_TIME.
module reaction_timer #(
   parameter int unsigned TICK_DIV  = 50000,
   parameter int unsigned MIN_DELAY = 1000,
   parameter int unsigned MAX_TIME  = 9999
) (
   input  logic        clk,
   input  logic        en,
   input  logic        start,
   input  logic        btn,
   output logic        led,
   output logic        done,
   output logic        foul,
   output logic [13:0] rectTime
);

   localparam int unsigned CW = $clog2(TICK_DIV + 1);
   localparam int unsigned DW = $clog2(MIN_DELAY + 2048 + 1);

   localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DLY_MIN   = DW'(MIN_DELAY);
   localparam logic [13:0]   RECT_MAX  = 14'(MAX_TIME);
   localparam logic [15:0]   LFSR_SEED = 16'hACE1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd1;
   localparam logic [2:0] ST_ARMED = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_FOUL  = 3'd4;

   logic          start_s1_q, start_s2_q, start_s3_q, start_arm_q;
   logic          btn_s1_q, btn_s2_q, btn_s3_q, btn_arm_q;
   logic          run_q;
   logic          start_p, press_p;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick;
   logic [15:0]   lfsr_q;
   logic [2:0]    state_q, state_d;
   logic [DW-1:0] delay_q, delay_d;
   logic [13:0]   rect_q, rect_d;
   logic          led_q, led_d, done_q, done_d, foul_q, foul_d;

   // An edge only counts once the synchronized level has been seen low after reset, so a
   // button already held when en releases cannot fake a press.
   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         start_s1_q  <= 1'b0;
         start_s2_q  <= 1'b0;
         start_s3_q  <= 1'b0;
         start_arm_q <= 1'b0;
         btn_s1_q    <= 1'b0;
         btn_s2_q    <= 1'b0;
         btn_s3_q    <= 1'b0;
         btn_arm_q   <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         start_s1_q  <= start;
         start_s2_q  <= start_s1_q;
         start_s3_q  <= start_s2_q;
         start_arm_q <= start_arm_q | (run_q & ~start_s1_q);
         btn_s1_q    <= btn;
         btn_s2_q    <= btn_s1_q;
         btn_s3_q    <= btn_s2_q;
         btn_arm_q   <= btn_arm_q | (run_q & ~btn_s1_q);
         run_q       <= 1'b1;
      end
   end

   assign start_p = start_arm_q & start_s2_q & ~start_s3_q;
   assign press_p = btn_arm_q & btn_s2_q & ~btn_s3_q;
   assign tick    = (cnt_q == CNT_MAX);

   always_comb begin
      state_d = state_q;
      delay_d = delay_q;
      rect_d  = rect_q;
      led_d   = led_q;
      done_d  = done_q;
      foul_d  = foul_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_FOUL: begin
            if (start_p) begin
               state_d = ST_WAIT;
               delay_d = DLY_MIN + DW'(lfsr_q[10:0]);
               rect_d  = '0;
               led_d   = 1'b0;
               done_d  = 1'b0;
               foul_d  = 1'b0;
            end
         end
         ST_WAIT: begin
            if (press_p) begin
               state_d = ST_FOUL;
               foul_d  = 1'b1;
               led_d   = 1'b0;
            end else if (tick) begin
               if (delay_q == DW'(1)) begin
                  state_d = ST_ARMED;
                  delay_d = '0;
                  led_d   = 1'b1;
               end else begin
                  delay_d = delay_q - DW'(1);
               end
            end
         end
         ST_ARMED: begin
            if (press_p) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               led_d   = 1'b0;
            end else if (tick) begin
               if (rect_q >= RECT_MAX - 14'd1) begin
                  state_d = ST_DONE;
                  rect_d  = RECT_MAX;
                  done_d  = 1'b1;
                  led_d   = 1'b0;
               end else begin
                  rect_d = rect_q + 14'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Restarting the prescaler on every transition makes each phase last whole ms.
   always_comb begin
      if (state_d != state_q || tick) cnt_d = '0;
      else                            cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         delay_q <= '0;
         rect_q  <= '0;
         led_q   <= 1'b0;
         done_q  <= 1'b0;
         foul_q  <= 1'b0;
         lfsr_q  <= LFSR_SEED;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         delay_q <= delay_d;
         rect_q  <= rect_d;
         led_q   <= led_d;
         done_q  <= done_d;
         foul_q  <= foul_d;
         lfsr_q  <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      end
   end

   assign led      = led_q;
   assign done     = done_q;
   assign foul     = foul_q;
   assign rectTime = rect_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with TICK_DIV=4, MIN_DELAY=2, MAX_TIME=50.
// The expected pre-stimulus delay comes from an independent copy of the x^16+x^14+x^13+x^11 LFSR.
module tb_reaction_timer;

   localparam int TD = 4;
   localparam int MD = 2;
   localparam int MT = 50;

   logic        clk = 1'b0;
   logic        en = 1'b0;
   logic        start = 1'b0;
   logic        btn = 1'b0;
   logic        led, done, foul;
   logic [13:0] rect;
   logic [15:0] m_lfsr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int press_edge;
      int exp_rect;
      int exp_done;
      int exp_led;
      int exp_foul;
   } vec_t;

   vec_t vecs[5];

   reaction_timer #(
      .TICK_DIV  (TD),
      .MIN_DELAY (MD),
      .MAX_TIME  (MT)
   ) dut (
      .clk      (clk),
      .en       (en),
      .start    (start),
      .btn      (btn),
      .led      (led),
      .done     (done),
      .foul     (foul),
      .rectTime (rect)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge en) begin
      if (!en) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Raw start rises just after an edge; the FSM acts on the third edge and loads from the
   // LFSR value it holds just before that edge.
   task automatic do_start(output int d);
      start = 1'b1;
      step(2);
      d = MD + int'(m_lfsr[10:0]);
      step(1);
      start = 1'b0;
      check("start_led", led, 0);
      check("start_done", done, 0);
      check("start_foul", foul, 0);
      check("start_rect", rect, 0);
   endtask

   task automatic wait_led(input int d);
      int  n    = 0;
      bit  seen = 1'b0;
      while (n < 9000 && !seen) begin
         step(1);
         n++;
         if (led === 1'b1) seen = 1'b1;
      end
      check("delay_cycles", seen ? n : -1, TD * d);
   endtask

   // Makes the press land on edge (A + e), where A is the edge that lit the lamp.
   task automatic press_at(input int e);
      step(e - 3);
      btn = 1'b1;
      step(3);
      btn = 1'b0;
   endtask

   initial begin
      int d, d2, hold_rect;

      vecs[0] = '{press_edge: 150, exp_rect: 37, exp_done: 1, exp_led: 0, exp_foul: 0};
      vecs[1] = '{press_edge: 52,  exp_rect: 12, exp_done: 1, exp_led: 0, exp_foul: 0};
      vecs[2] = '{press_edge: 53,  exp_rect: 13, exp_done: 1, exp_led: 0, exp_foul: 0};
      vecs[3] = '{press_edge: 4,   exp_rect: 0,  exp_done: 1, exp_led: 0, exp_foul: 0};
      vecs[4] = '{press_edge: 230, exp_rect: 50, exp_done: 1, exp_led: 0, exp_foul: 0};

      step(2);
      check("rst_led", led, 0);
      check("rst_done", done, 0);
      check("rst_foul", foul, 0);
      check("rst_rect", rect, 0);
      en = 1'b1;
      step(4);

      for (int i = 0; i < 5; i++) begin
         do_start(d);
         wait_led(d);
         press_at(vecs[i].press_edge);
         check("run_rect", rect, vecs[i].exp_rect);
         check("run_done", done, vecs[i].exp_done);
         check("run_led", led, vecs[i].exp_led);
         check("run_foul", foul, vecs[i].exp_foul);
         step(8);
         check("hold_rect", rect, vecs[i].exp_rect);
         check("hold_done", done, vecs[i].exp_done);
      end

      // Press lands on the same edge as the delay expiry: foul must win.
      do_start(d);
      step(TD * d - 3);
      btn = 1'b1;
      step(3);
      btn = 1'b0;
      check("foul_flag", foul, 1);
      check("foul_led", led, 0);
      check("foul_done", done, 0);
      check("foul_rect", rect, 0);
      step(12);
      check("foul_led_stays", led, 0);
      check("foul_hold", foul, 1);
      do_start(d2);
      wait_led(d2);
      press_at(10);
      check("after_foul_rect", rect, 2);
      check("after_foul_done", done, 1);

      // Abort in ARMED at rectTime 7, then release reset with start held.
      do_start(d);
      wait_led(d);
      step(28);
      hold_rect = 7;
      check("pre_rst_rect", rect, hold_rect);
      check("pre_rst_led", led, 1);
      start = 1'b1;
      #2;
      en = 1'b0;
      #1;
      check("async_rst_led", led, 0);
      check("async_rst_done", done, 0);
      check("async_rst_foul", foul, 0);
      check("async_rst_rect", rect, 0);
      step(2);
      en = 1'b1;
      step(6);
      btn = 1'b1;
      step(4);
      btn = 1'b0;
      step(1);
      check("held_start_no_wait", foul, 0);
      check("held_start_led", led, 0);
      check("held_start_done", done, 0);
      start = 1'b0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
